// File: rtl/types_pkg.sv
// Shared types for the unified memory controller: word/address types, FSM states, fetch filler.
package types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] address_t;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} umc_state_t;
  localparam word_t NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/umc_ram.sv
// Synchronous single-port RAM, per-byte write enables, registered read (old data on write).
module umc_ram
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);
  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/unified_mem_ctrl.sv
// Arbitrates fetch and data requests onto one single-port RAM, one transaction per WAIT_STATES+2 cycles.
// Optional perf counters (fetches, data accesses, stall cycles) are built when UMC_PERF_EN is defined.
module unified_mem_ctrl
  import types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     if_req,
  input  address_t if_addr,
  output word_t    if_rdata,
  output logic     if_ready,
  input  logic     d_req,
  input  logic     d_we,
  input  logic [3:0] d_be,
  input  address_t d_addr,
  input  word_t    d_wdata,
  output word_t    d_rdata,
  output logic     d_ready,
  output logic     d_err,
`ifdef UMC_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_data_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic     stall
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  umc_state_t state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       fair;
  logic       grant, grant_d;
  logic       cur_d, cur_we, cur_oor;
  logic [3:0] cur_be;
  address_t   cur_addr;
  word_t      cur_wdata;
  logic       if_rdy_q, d_rdy_q, d_err_q;
  word_t      ram_q, if_hold, d_hold;

  assign cur_oor = cur_addr[31:2] >= 30'(DEPTH_WORDS);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant = 1'b1;
          // fetch takes precedence only when it was kept waiting by the last data grant
          grant_d = d_req && !(if_req && fair);
          if (WAIT_STATES == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT;
            wcnt_nxt  = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (wcnt == 4'd0) state_nxt = ACCESS;
        else              wcnt_nxt  = wcnt - 4'd1;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      fair      <= 1'b0;
      cur_d     <= 1'b0;
      cur_we    <= 1'b0;
      cur_be    <= 4'd0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      if_rdy_q  <= 1'b0;
      d_rdy_q   <= 1'b0;
      d_err_q   <= 1'b0;
      if_hold   <= '0;
      d_hold    <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (grant) begin
        cur_d     <= grant_d;
        cur_we    <= grant_d & d_we;
        cur_be    <= d_be;
        cur_addr  <= grant_d ? d_addr : if_addr;
        cur_wdata <= d_wdata;
        fair      <= grant_d & if_req;
      end else if (state != IDLE && cur_d && if_req) begin
        fair <= 1'b1;
      end
      if_rdy_q <= (state == ACCESS) && !cur_d;
      d_rdy_q  <= (state == ACCESS) && cur_d;
      d_err_q  <= (state == ACCESS) && cur_d && (cur_oor || cur_addr[1:0] != 2'b00);
      if (if_rdy_q) if_hold <= if_rdata;
      if (d_rdy_q)  d_hold  <= d_rdata;
    end
  end

  umc_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (state == ACCESS),
    .we    (cur_d && cur_we && !cur_oor),
    .be    (cur_be),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // cur_* stays latched through the ready cycle, so it still describes the completing access
  assign if_rdata = if_rdy_q ? (cur_oor ? NOP_INSTR : ram_q) : if_hold;
  assign d_rdata  = d_rdy_q ? ((cur_oor || cur_we) ? 32'h0 : ram_q) : d_hold;
  assign if_ready = if_rdy_q;
  assign d_ready  = d_rdy_q;
  assign d_err    = d_err_q;
  assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef UMC_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_data_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (if_rdy_q) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (d_rdy_q)  perf_data_cnt  <= perf_data_cnt + 32'd1;
      if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit RAM words; SHALL be a power of two.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles per access, range 0..15.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port if_req  input  1  fetch request, held until if_ready.
REQ-006 Port if_addr  input  32 (address_t)  fetch byte address.
REQ-007 Port if_rdata  output  32 (word_t)  fetched instruction, valid while if_ready.
REQ-008 Port if_ready  output  1  one-cycle fetch-completion pulse.
REQ-009 Port d_req  input  1  data request, held until d_ready.
REQ-010 Port d_we  input  1  1 = write, 0 = read.
REQ-011 Port d_be  input  4  byte enables for writes, bit i selects byte i.
REQ-012 Port d_addr  input  32 (address_t)  data byte address.
REQ-013 Port d_wdata  input  32 (word_t)  write data.
REQ-014 Port d_rdata  output  32 (word_t)  read data, valid while d_ready.
REQ-015 Port d_ready  output  1  one-cycle data-completion pulse.
REQ-016 Port d_err  output  1  pulses with d_ready on misaligned or out-of-range data access.
REQ-017 Port stall  output  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready).

Function
REQ-018 Block SHALL arbitrate fetch and data ports onto one single-port RAM, one transaction at a time.
REQ-019 FSM states: IDLE, WAIT, ACCESS; IDLE -> WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0) on grant; WAIT -> ACCESS when wait counter reaches 0; ACCESS -> IDLE unconditionally.
REQ-020 Grant at edge E0 SHALL latch port, address, we, be, wdata; RAM access occurs at edge E0+WAIT_STATES+1; ready pulses in the following cycle.
REQ-021 Ready cycle is spent in IDLE; a request present at the edge ending the ready cycle SHALL be granted (one transaction per WAIT_STATES+2 cycles).
REQ-022 Arbitration: data wins simultaneous requests unless the previous grant was data and fetch was waiting, in which case fetch wins (no port starved beyond one transaction).
REQ-023 Word index = addr[31:2]; addr[1:0] ignored for access but nonzero data addr[1:0] SHALL set d_err.
REQ-024 Word index >= DEPTH_WORDS: read returns 0x0000_0000, write suppressed, d_err pulsed; fetch out-of-range returns 0x0000_0013 (nop).
REQ-025 Writes SHALL update only bytes with d_be set; d_rdata during a write's ready cycle SHALL be 0.
REQ-026 if_rdata/d_rdata SHALL hold their last value outside ready cycles.

Reset
REQ-027 Reset SHALL force IDLE, wait counter 0, fairness flag cleared, if_ready/d_ready/d_err 0, if_rdata/d_rdata 0.
REQ-028 Reset mid-transaction SHALL abort it: no RAM write, no ready pulse; RAM contents not cleared.

Configuration
REQ-029 Macro UMC_PERF_EN defined: outputs perf_fetch_cnt, perf_data_cnt, perf_stall_cnt (32 bits each) SHALL count completed fetches, completed data accesses and cycles with stall=1, wrapping at 2^32, cleared by reset.
REQ-030 UMC_PERF_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 word_t, address_t, umc_state_t (enum IDLE/WAIT/ACCESS) and NOP_INSTR constant SHALL live in types_pkg.
REQ-032 RAM SHALL be sub-module umc_ram: synchronous single-port, byte-enable write, registered read.

Verification
REQ-033 WAIT_STATES=1, if_req, if_addr=0x0000_0010 -> if_ready exactly 3 cycles after grant edge, if_rdata = word 4, stall high until then.
REQ-034 Write d_addr=0x20, d_be=0b0011, d_wdata=0xAABB_CCDD over 0x1122_3344 -> later read returns 0x1122_CCDD.
REQ-035 Both ports request continuously -> grant order data, fetch, data, fetch; no two consecutive fetch-starved grants.
REQ-036 d_addr=0x0000_1002 (DEPTH_WORDS=1024) read -> d_ready with d_err=1, d_rdata=0; write to same address leaves RAM unchanged.
REQ-037 reset asserted during WAIT of a write -> no write, no d_ready, state IDLE; with UMC_PERF_EN, counters read 0 after reset.
